// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm scanner: state encoding, default input
// count and the truth-table width derivation.
package minterm_pkg;

    localparam int N_VARS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int tt_width(input int n_vars);
        return 1 << n_vars;
    endfunction

endpackage

// File: rtl/minterm_scanner.sv
// Serially emits the index of every set bit of a captured truth table, in
// ascending order, over a valid/ready stream, and counts the minterms sent.
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [tt_width(N_VARS)-1:0]   tt,
    output logic                          busy,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [N_VARS-1:0]             m_index,
    output logic                          m_last,
    output logic                          done,
    output logic [N_VARS:0]               count
);

    localparam int                TT_W      = tt_width(N_VARS);
    localparam logic [N_VARS-1:0] IDX_MAX   = N_VARS'(TT_W - 1);
    localparam logic [N_VARS-1:0] IDX_ONE   = N_VARS'(1);
    localparam logic [N_VARS:0]   COUNT_ONE = (N_VARS + 1)'(1);

    state_t              state_q, state_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [N_VARS-1:0]   idx_q, idx_d;
    logic [N_VARS:0]     count_q, count_d;
    logic [TT_W-1:0]     above_mask;
    logic                upper_zero;

    // Bits strictly above idx; when none are set this is the final minterm.
    always_comb begin
        above_mask = ({TT_W{1'b1}} << idx_q) << 1;
        upper_zero = ~|(tt_q & above_mask);
    end

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d    = tt;
                    idx_d   = '0;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (tt_q[idx_q]) begin
                    state_d = EMIT;
                end else if (idx_q == IDX_MAX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            EMIT: begin
                if (m_ready) begin
                    count_d = count_q + COUNT_ONE;
                    if (upper_zero) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tt_q    <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Outputs depend on registered state only; m_ready never reaches m_valid.
    always_comb begin
        busy    = (state_q != IDLE);
        m_valid = (state_q == EMIT);
        m_index = idx_q;
        m_last  = (state_q == EMIT) && upper_zero;
        done    = (state_q == DONE);
        count   = count_q;
    end

endmodule

// File: tb/tb_minterm_scanner.sv
// Randomised bench for minterm_scanner against a timeline model built from
// the list of set bits and per-minterm stall lengths.
module tb_minterm_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] tt;
    logic        busy;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_index;
    logic        m_last;
    logic        done;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    int got[$];

    minterm_scanner #(.N_VARS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tt      (tt),
        .busy    (busy),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .m_last  (m_last),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one scan from an IDLE negedge. Minterm k first appears in
    // cycle index+2 plus all earlier hold times, and is held 1+stall cycles.
    task automatic run_scan(input logic [15:0] tv, input int stall_mode,
                            input bit poke_start, input int abort_cycle,
                            output int done_cyc);
        int mt[$];
        int stl[$];
        int st[$];
        int acc;
        int n;
        int ek;
        int ecount;
        mt.delete(); stl.delete(); st.delete(); got.delete();
        for (int i = 0; i < 16; i++) begin
            if (tv[i]) begin
                mt.push_back(i);
                stl.push_back(stall_mode < 0 ? int'($urandom_range(0, 3)) : stall_mode);
            end
        end
        n = mt.size();
        acc = 0;
        for (int k = 0; k < n; k++) begin
            st.push_back(mt[k] + 2 + acc);
            acc += 1 + stl[k];
        end
        done_cyc = (n > 0) ? st[n-1] + 1 + stl[n-1] : 17;

        start = 1'b1;
        tt    = tv;
        @(posedge clk);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            tt    = 16'($urandom);
            ek = -1;
            ecount = 0;
            for (int k = 0; k < n; k++) begin
                if (st[k] <= c && c < st[k] + 1 + stl[k]) ek = k;
                if (st[k] + 1 + stl[k] <= c) ecount++;
            end
            if (c == abort_cycle) begin
                rst_n = 1'b0;
                #1;
                chk("abort_m_valid", int'(m_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_count", int'(count), 0);
                chk("abort_m_index", int'(m_index), 0);
                chk("abort_m_last", int'(m_last), 0);
                chk("abort_done", int'(done), 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("m_valid", int'(m_valid), int'(ek >= 0));
            chk("busy", int'(busy), int'(c <= done_cyc));
            chk("done", int'(done), int'(c == done_cyc));
            chk("count", int'(count), ecount);
            if (ek >= 0) begin
                chk("m_index", int'(m_index), mt[ek]);
                chk("m_last", int'(m_last), int'(ek == n - 1));
                m_ready = ((c - st[ek]) >= stl[ek]);
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            if (m_valid && m_ready) got.push_back(int'(m_index));
            if (poke_start && c < done_cyc) begin
                start = 1'b1;
                tt    = ~tv ^ 16'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        int d;
        int exp_1894[5] = '{2, 4, 7, 11, 12};
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b1;
        tt      = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_index", int'(m_index), 0);
        chk("rst_m_last", int'(m_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(16'h1894, 0, 1'b0, -1, d);
        chk("sop_done_cycle", d, 19);
        chk("sop_emitted", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("sop_index", got[k], exp_1894[k]);

        run_scan(16'h0000, 0, 1'b0, -1, d);
        chk("zero_done_cycle", d, 17);
        chk("zero_emitted", got.size(), 0);

        run_scan(16'hFFFF, 0, 1'b0, -1, d);
        chk("ones_done_cycle", d, 33);
        chk("ones_emitted", got.size(), 16);
        if (got.size() == 16) chk("ones_last_index", got[15], 15);

        run_scan(16'h8001, 3, 1'b0, -1, d);
        chk("stall_done_cycle", d, 25);
        chk("stall_emitted", got.size(), 2);

        run_scan(16'h1894, 0, 1'b1, -1, d);
        chk("poke_emitted", got.size(), 5);

        run_scan(16'h1894, 0, 1'b0, 7, d);
        run_scan(16'h1894, 0, 1'b0, -1, d);
        chk("post_reset_emitted", got.size(), 5);
        if (got.size() > 0) chk("post_reset_first", got[0], 2);

        for (int r = 0; r < 25; r++) begin
            logic [15:0] rt;
            rt = 16'($urandom);
            if (r == 3) rt = 16'h8000;
            if (r == 4) rt = 16'h0001;
            run_scan(rt, -1, 1'($urandom_range(0, 1)), -1, d);
            chk("rand_emitted", got.size(), $countones(rt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
